// File: rtl/vslc_spi_eeprom_target.sv
// SPI mode-0 responder emulating a 25xx serial EEPROM read path (0x03, 8-bit address, streamed data).
// Optional: define VSLC_SPI_EEPROM_WRITE_EN to add WREN (0x06), RDSR (0x05) and WRITE (0x02).
module vslc_spi_eeprom_target #(
  parameter int   DEPTH       = 256,
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_CIPO   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_sck,
  input  logic       spi_cs_n,
  input  logic       spi_copi,
  output logic       spi_cipo,
  output logic       spi_cipo_oe,
  input  logic       prog_we,
  input  logic [7:0] prog_addr,
  input  logic [7:0] prog_wdata,
  output logic       prog_drop,
  output logic       busy,
  output logic       cmd_err
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] OP_READ  = 8'h03;
`ifdef VSLC_SPI_EEPROM_WRITE_EN
  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_WRITE = 8'h02;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DATA_OUT, S_IGNORE, S_WR_DATA
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES:0]   sck_q;
  logic [SYNC_STAGES-1:0] cs_q;
  logic [SYNC_STAGES-1:0] copi_q;
  logic                   sck_s, sck_p, cs_s, copi_s, sck_rise, sck_fall;
  logic [2:0]             bitcnt;
  logic [6:0]             shreg;
  logic [6:0]             tx;
  logic [7:0]             ptr;
  logic [7:0]             rx_byte, mem_at_rx, mem_at_ptr, next_byte;
  logic                   rose, load_pend, spi_we;
  logic [7:0]             mem [DEPTH];

  function automatic logic [AW-1:0] idx(input logic [7:0] a);
    return AW'(32'(a) % DEPTH);
  endfunction

  // sck keeps one extra flop so edges are detected on already-synchronized samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_q  <= '0;
      cs_q   <= '1;
      copi_q <= '0;
    end else begin
      sck_q  <= {sck_q[SYNC_STAGES-1:0], spi_sck};
      cs_q   <= {cs_q[SYNC_STAGES-2:0], spi_cs_n};
      copi_q <= {copi_q[SYNC_STAGES-2:0], spi_copi};
    end
  end

  assign sck_s    = sck_q[SYNC_STAGES-1];
  assign sck_p    = sck_q[SYNC_STAGES];
  assign cs_s     = cs_q[SYNC_STAGES-1];
  assign copi_s   = copi_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_p & ~cs_s;
  assign sck_fall = ~sck_s & sck_p & ~cs_s;

  assign rx_byte    = {shreg, copi_s};
  assign mem_at_rx  = mem[idx(rx_byte)];
  assign mem_at_ptr = mem[idx(ptr)];

`ifdef VSLC_SPI_EEPROM_WRITE_EN
  logic       wel, wel_set, wel_clr, sr_mode, wr_mode;
  logic [7:0] status;
  assign status    = {6'b0, wel, 1'b0};
  assign next_byte = sr_mode ? status : mem_at_ptr;
  assign spi_we    = (state == S_WR_DATA) && sck_rise && (bitcnt == 3'd0);
`else
  assign next_byte = mem_at_ptr;
  assign spi_we    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      bitcnt      <= 3'd7;
      shreg       <= '0;
      tx          <= '0;
      ptr         <= '0;
      rose        <= 1'b0;
      load_pend   <= 1'b0;
      spi_cipo    <= IDLE_CIPO;
      spi_cipo_oe <= 1'b0;
      busy        <= 1'b0;
      cmd_err     <= 1'b0;
`ifdef VSLC_SPI_EEPROM_WRITE_EN
      wel         <= 1'b0;
      wel_set     <= 1'b0;
      wel_clr     <= 1'b0;
      sr_mode     <= 1'b0;
      wr_mode     <= 1'b0;
`endif
    end else begin
      busy    <= ~cs_s;
      cmd_err <= 1'b0;
      if (cs_s) begin
        // deselect aborts any frame; a partial byte is simply dropped
        state       <= S_IDLE;
        bitcnt      <= 3'd7;
        rose        <= 1'b0;
        load_pend   <= 1'b0;
        spi_cipo    <= IDLE_CIPO;
        spi_cipo_oe <= 1'b0;
`ifdef VSLC_SPI_EEPROM_WRITE_EN
        wel     <= (wel | wel_set) & ~wel_clr;
        wel_set <= 1'b0;
        wel_clr <= 1'b0;
        sr_mode <= 1'b0;
        wr_mode <= 1'b0;
`endif
      end else begin
        case (state)
          S_IDLE: begin
            state  <= S_CMD;
            bitcnt <= 3'd7;
          end
          S_CMD: if (sck_rise) begin
            shreg  <= rx_byte[6:0];
            bitcnt <= bitcnt - 3'd1;
            if (bitcnt == 3'd0) begin
              if (rx_byte == OP_READ) state <= S_ADDR;
`ifdef VSLC_SPI_EEPROM_WRITE_EN
              else if (rx_byte == OP_WREN) begin
                wel_set <= 1'b1;
                state   <= S_IGNORE;
              end else if (rx_byte == OP_RDSR) begin
                sr_mode     <= 1'b1;
                tx          <= status[6:0];
                spi_cipo    <= status[7];
                spi_cipo_oe <= 1'b1;
                rose        <= 1'b0;
                load_pend   <= 1'b0;
                state       <= S_DATA_OUT;
              end else if (rx_byte == OP_WRITE && wel) begin
                wr_mode <= 1'b1;
                wel_clr <= 1'b1;
                state   <= S_ADDR;
              end
`endif
              else begin
                cmd_err <= 1'b1;
                state   <= S_IGNORE;
              end
            end
          end
          S_ADDR: if (sck_rise) begin
            shreg  <= rx_byte[6:0];
            bitcnt <= bitcnt - 3'd1;
            if (bitcnt == 3'd0) begin
              ptr <= rx_byte;
`ifdef VSLC_SPI_EEPROM_WRITE_EN
              if (wr_mode) state <= S_WR_DATA;
              else
`endif
              begin
                tx          <= mem_at_rx[6:0];
                spi_cipo    <= mem_at_rx[7];
                spi_cipo_oe <= 1'b1;
                rose        <= 1'b0;
                load_pend   <= 1'b0;
                state       <= S_DATA_OUT;
              end
            end
          end
          S_DATA_OUT: begin
            // the fall right after the address byte must not shift: MSB is already out
            if (sck_rise) begin
              rose   <= 1'b1;
              bitcnt <= bitcnt - 3'd1;
              if (bitcnt == 3'd0) begin
                load_pend <= 1'b1;
                ptr       <= ptr + 8'd1;
              end
            end else if (sck_fall && rose) begin
              rose <= 1'b0;
              if (load_pend) begin
                load_pend <= 1'b0;
                tx        <= next_byte[6:0];
                spi_cipo  <= next_byte[7];
              end else begin
                tx       <= {tx[5:0], 1'b0};
                spi_cipo <= tx[6];
              end
            end
          end
`ifdef VSLC_SPI_EEPROM_WRITE_EN
          S_WR_DATA: if (sck_rise) begin
            shreg  <= rx_byte[6:0];
            bitcnt <= bitcnt - 3'd1;
            if (bitcnt == 3'd0) ptr <= ptr + 8'd1;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prog_drop <= 1'b0;
    else     prog_drop <= prog_we & busy;
  end

  // storage is intentionally not reset
  always_ff @(posedge clk) begin
    if (spi_we)                mem[idx(ptr)]       <= rx_byte;
    else if (prog_we && !busy) mem[idx(prog_addr)] <= prog_wdata;
  end
endmodule

// File: tb/tb_vslc_spi_eeprom_target.sv
// Self-checking bench for vslc_spi_eeprom_target: bench-side SPI master, byte-array model, per-cycle monitor.
module tb_vslc_spi_eeprom_target;
  localparam int   H    = 4;
  localparam int   SYNC = 2;
  localparam logic IDLE = 1'b0;

  logic       clk = 1'b0, rst = 1'b1;
  logic       spi_sck = 1'b0, spi_cs_n = 1'b1, spi_copi = 1'b0;
  logic       prog_we = 1'b0;
  logic [7:0] prog_addr = '0, prog_wdata = '0;
  logic       spi_cipo, spi_cipo_oe, prog_drop, busy, cmd_err;

  int         n_checks = 0, n_fail = 0, err_pulses = 0, drop_pulses = 0;
  logic [7:0] model [256];
  logic [7:0] rxq [$];

  vslc_spi_eeprom_target #(.DEPTH(256), .SYNC_STAGES(SYNC), .IDLE_CIPO(IDLE)) dut (
    .clk(clk), .rst(rst), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_copi(spi_copi),
    .spi_cipo(spi_cipo), .spi_cipo_oe(spi_cipo_oe), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .prog_drop(prog_drop), .busy(busy), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // every-cycle rules: idle CIPO level whenever not driving, busy tracks a settled cs_n
  initial begin : monitor
    int   stable;
    logic last;
    stable = 0;
    last   = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (spi_cs_n === last) stable++;
        else stable = 0;
        last = spi_cs_n;
        if (cmd_err)   err_pulses++;
        if (prog_drop) drop_pulses++;
        if (!spi_cipo_oe) chk("cipo_idle_level", spi_cipo, IDLE);
        if (stable >= SYNC + 2) begin
          if (spi_cs_n) begin
            chk("busy_when_deselected", busy, 0);
            chk("oe_when_deselected", spi_cipo_oe, 0);
          end else begin
            chk("busy_when_selected", busy, 1);
          end
        end
      end
    end
  end

  task automatic spi_bits(input logic [7:0] txb, input int nb, output logic [7:0] rx,
                          output logic oe_all, output logic oe_any);
    oe_all = 1'b1; oe_any = 1'b0; rx = '0;
    for (int i = 7; i > 7 - nb; i--) begin
      spi_copi = txb[i];
      tick(H);
      rx[i]  = spi_cipo;
      oe_all = oe_all & spi_cipo_oe;
      oe_any = oe_any | spi_cipo_oe;
      spi_sck = 1'b1;
      tick(H);
      spi_sck = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] txb, output logic [7:0] rx,
                          output logic oe_all, output logic oe_any);
    spi_bits(txb, 8, rx, oe_all, oe_any);
  endtask

  task automatic frame_begin();
    spi_cs_n = 1'b0;
    tick(H);
  endtask

  task automatic frame_end();
    tick(H);
    spi_cs_n = 1'b1;
    tick(3 * H);
  endtask

  task automatic prog(input logic [7:0] a, input logic [7:0] d);
    prog_addr = a; prog_wdata = d; prog_we = 1'b1;
    tick(1);
    prog_we = 1'b0;
  endtask

  // read frame with a command byte; received data bytes land in rxq
  task automatic read_frame(input string name, input logic [7:0] op, input logic [7:0] addr,
                            input bit has_addr, input int nbytes);
    logic [7:0] rx;
    logic all, any;
    int e0;
    e0 = err_pulses;
    rxq.delete();
    frame_begin();
    spi_byte(op, rx, all, any);
    chk({name, "_oe_in_cmd"}, any, 0);
    if (has_addr) begin
      spi_byte(addr, rx, all, any);
      chk({name, "_oe_in_addr"}, any, 0);
    end
    for (int i = 0; i < nbytes; i++) begin
      spi_byte(8'($urandom), rx, all, any);
      chk($sformatf("%s_oe_data%0d", name, i), all, 1);
      rxq.push_back(rx);
    end
    frame_end();
    chk({name, "_no_cmd_err"}, err_pulses - e0, 0);
  endtask

  task automatic read_vs_model(input string name, input logic [7:0] addr, input int nbytes);
    read_frame(name, 8'h03, addr, 1'b1, nbytes);
    for (int i = 0; i < nbytes; i++)
      chk($sformatf("%s_byte%0d", name, i), rxq[i], model[8'(int'(addr) + i)]);
  endtask

  task automatic bad_opcode(input string name, input logic [7:0] op);
    logic [7:0] rx;
    logic all, any;
    int e0;
    e0 = err_pulses;
    frame_begin();
    spi_byte(op, rx, all, any);
    spi_byte(8'($urandom), rx, all, any);
    chk({name, "_oe_after_bad_op"}, any, 0);
    spi_byte(8'($urandom), rx, all, any);
    chk({name, "_oe_after_bad_op2"}, any, 0);
    frame_end();
    chk({name, "_cmd_err_pulses"}, err_pulses - e0, 1);
  endtask

  task automatic abort_frame(input string name, input int addr_bits, input int data_bits);
    logic [7:0] rx;
    logic all, any;
    int e0;
    e0 = err_pulses;
    frame_begin();
    spi_byte(8'h03, rx, all, any);
    if (addr_bits > 0) spi_bits(8'($urandom), addr_bits, rx, all, any);
    if (addr_bits == 8 && data_bits > 0) spi_bits(8'hFF, data_bits, rx, all, any);
    spi_cs_n = 1'b1;
    tick(SYNC + 2);
    chk({name, "_busy_after_abort"}, busy, 0);
    chk({name, "_oe_after_abort"}, spi_cipo_oe, 0);
    tick(2 * H);
    chk({name, "_no_cmd_err"}, err_pulses - e0, 0);
  endtask

`ifdef VSLC_SPI_EEPROM_WRITE_EN
  task automatic send_bytes(input string name, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input int n, input int exp_err);
    logic [7:0] rx;
    logic all, any;
    int e0;
    e0 = err_pulses;
    frame_begin();
    spi_byte(b0, rx, all, any);
    if (n > 1) spi_byte(b1, rx, all, any);
    if (n > 2) spi_byte(b2, rx, all, any);
    frame_end();
    chk({name, "_cmd_err_pulses"}, err_pulses - e0, exp_err);
  endtask
`endif

  initial begin : stim
    logic [7:0] a, d, op;
    int d0, kind;

    tick(3);
    chk("reset_cipo", spi_cipo, IDLE);
    chk("reset_oe", spi_cipo_oe, 0);
    chk("reset_busy", busy, 0);
    chk("reset_prog_drop", prog_drop, 0);
    chk("reset_cmd_err", cmd_err, 0);
    rst = 1'b0;
    tick(4);

    for (int i = 0; i < 256; i++) begin
      model[i] = 8'($urandom);
      prog(8'(i), model[i]);
    end
    tick(2);
    chk("preload_no_drop", drop_pulses, 0);

    // directed, with literal expectations
    prog(8'h00, 8'h10); model[8'h00] = 8'h10;
    prog(8'h01, 8'h20); model[8'h01] = 8'h20;
    read_frame("tp_read0", 8'h03, 8'h00, 1'b1, 2);
    chk("tp_read0_b0", rxq[0], 8'h10);
    chk("tp_read0_b1", rxq[1], 8'h20);

    prog(8'hFF, 8'hA5); model[8'hFF] = 8'hA5;
    prog(8'h00, 8'h5A); model[8'h00] = 8'h5A;
    read_frame("tp_wrap", 8'h03, 8'hFF, 1'b1, 3);
    chk("tp_wrap_b0", rxq[0], 8'hA5);
    chk("tp_wrap_b1", rxq[1], 8'h5A);
    chk("tp_wrap_b2", rxq[2], 8'h20);

    abort_frame("tp_abort5", 5, 0);
    read_frame("tp_after_abort", 8'h03, 8'h01, 1'b1, 1);
    chk("tp_after_abort_b0", rxq[0], 8'h20);

    bad_opcode("tp_op9f", 8'h9F);

    prog(8'h10, 8'h77); model[8'h10] = 8'h77;
    frame_begin();
    tick(8);
    d0 = drop_pulses;
    prog(8'h10, 8'h33);
    tick(2);
    chk("tp_busy_prog_drop", drop_pulses - d0, 1);
    frame_end();
    read_frame("tp_busy_prog", 8'h03, 8'h10, 1'b1, 1);
    chk("tp_busy_prog_unchanged", rxq[0], 8'h77);
    d0 = drop_pulses;
    prog(8'h10, 8'h33); model[8'h10] = 8'h33;
    tick(2);
    chk("tp_idle_prog_no_drop", drop_pulses - d0, 0);
    read_frame("tp_idle_prog", 8'h03, 8'h10, 1'b1, 1);
    chk("tp_idle_prog_value", rxq[0], 8'h33);

    // prog_we on the synchronized cs_n falling-edge cycle still lands
    spi_cs_n = 1'b0;
    tick(SYNC);
    d0 = drop_pulses;
    prog(8'h22, 8'hC6); model[8'h22] = 8'hC6;
    tick(2);
    chk("tp_csfall_prog_no_drop", drop_pulses - d0, 0);
    frame_end();
    read_frame("tp_csfall_prog", 8'h03, 8'h22, 1'b1, 1);
    chk("tp_csfall_prog_value", rxq[0], 8'hC6);

`ifdef VSLC_SPI_EEPROM_WRITE_EN
    prog(8'h40, 8'h11); model[8'h40] = 8'h11;
    read_frame("tp_rdsr0", 8'h05, 8'h00, 1'b0, 2);
    chk("tp_rdsr0_b0", rxq[0], 8'h00);
    send_bytes("tp_write_nowel", 8'h02, 8'h40, 8'h99, 3, 1);
    read_frame("tp_write_nowel_rd", 8'h03, 8'h40, 1'b1, 1);
    chk("tp_write_nowel_unchanged", rxq[0], 8'h11);
    send_bytes("tp_wren", 8'h06, 8'h00, 8'h00, 1, 0);
    read_frame("tp_rdsr_wel", 8'h05, 8'h00, 1'b0, 2);
    chk("tp_rdsr_wel_b0", rxq[0], 8'h02);
    chk("tp_rdsr_wel_b1", rxq[1], 8'h02);
    send_bytes("tp_write", 8'h02, 8'h40, 8'hC3, 3, 0);
    model[8'h40] = 8'hC3;
    read_frame("tp_write_rd", 8'h03, 8'h40, 1'b1, 1);
    chk("tp_write_value", rxq[0], 8'hC3);
    read_frame("tp_rdsr_after_write", 8'h05, 8'h00, 1'b0, 1);
    chk("tp_rdsr_after_write_b0", rxq[0], 8'h00);
`endif

    // randomized traffic against the byte-array model
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: read_vs_model($sformatf("rnd%0d_read", it), 8'($urandom), $urandom_range(1, 3));
        1: begin
          a = 8'($urandom); d = 8'($urandom);
          d0 = drop_pulses;
          prog(a, d); model[a] = d;
          tick(2);
          chk($sformatf("rnd%0d_prog_no_drop", it), drop_pulses - d0, 0);
        end
        2: begin
          do begin
            op = 8'($urandom);
          end while (op == 8'h03
`ifdef VSLC_SPI_EEPROM_WRITE_EN
                     || op == 8'h02 || op == 8'h05 || op == 8'h06
`endif
                     );
          bad_opcode($sformatf("rnd%0d_badop", it), op);
        end
        default: abort_frame($sformatf("rnd%0d_abort", it), $urandom_range(0, 8), $urandom_range(1, 7));
      endcase
    end
    read_vs_model("final_read", 8'hFE, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
